// File: rtl/periph_map_pkg.sv
// Shared address-map constants and FSM encoding for the femtoriscv peripheral decoder.
package periph_map_pkg;

  localparam int CS_W = 7;

  localparam int CS_RAM     = 0;
  localparam int CS_BIN2BCD = 1;
  localparam int CS_DIV     = 2;
  localparam int CS_MULT    = 3;
  localparam int CS_GPIO    = 4;
  localparam int CS_UART    = 5;
  localparam int CS_DPRAM   = 6;

  // IO target codes carried in mem_addr[18:16]; 6 and 7 are unmapped
  localparam logic [2:0] SEL_DPRAM   = 3'd0;
  localparam logic [2:0] SEL_UART    = 3'd1;
  localparam logic [2:0] SEL_GPIO    = 3'd2;
  localparam logic [2:0] SEL_MULT    = 3'd3;
  localparam logic [2:0] SEL_DIV     = 3'd4;
  localparam logic [2:0] SEL_BIN2BCD = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_R = 2'd1,
    WAIT_W = 2'd2
  } state_t;

endpackage

// File: rtl/addr_region_decode.sv
// Combinational address decode: CPU byte address to 7-bit one-hot target select.
module addr_region_decode
  import periph_map_pkg::*;
(
  input  logic [31:0]     mem_addr,
  output logic [CS_W-1:0] onehot
);

  // Only bit 22 and the IO code field take part in the decode
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:23], mem_addr[21:19], mem_addr[15:0]};

  always_comb begin
    onehot = '0;
    if (!mem_addr[22]) begin
      onehot[CS_RAM] = 1'b1;
    end else begin
      case (mem_addr[18:16])
        SEL_DPRAM:   onehot[CS_DPRAM]   = 1'b1;
        SEL_UART:    onehot[CS_UART]    = 1'b1;
        SEL_GPIO:    onehot[CS_GPIO]    = 1'b1;
        SEL_MULT:    onehot[CS_MULT]    = 1'b1;
        SEL_DIV:     onehot[CS_DIV]     = 1'b1;
        SEL_BIN2BCD: onehot[CS_BIN2BCD] = 1'b1;
        default:     onehot = '0;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_decoder.sv
// Bus decoder ahead of the read-data mux: strobes, registered select, stall and error tracking.
// Define PERIPH_DEC_TIMEOUT_EN to build the wait counter that force-completes stuck accesses.
module peripheral_decoder
  import periph_map_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     mem_addr,
  input  logic            mem_rstrb,
  input  logic [3:0]      mem_wmask,
  input  logic [5:0]      io_ready,
  output logic [CS_W-1:0] rd,
  output logic [CS_W-1:0] wr,
  output logic [CS_W-1:0] cs,
  output logic            mem_rbusy,
  output logic            mem_wbusy,
  output logic            bus_err,
  output logic [31:0]     err_addr
);

  if (TIMEOUT < 2 || TIMEOUT > 255 || (1 << CNT_W) <= TIMEOUT) begin : g_bad_params
    $error("peripheral_decoder: TIMEOUT must be 2..255 and fit in CNT_W bits");
  end

  state_t          state_reg, state_next;
  logic [CS_W-1:0] decoded;
  logic            idle, wr_acc, rd_acc, acc;
  logic            sel_ready, timeout_hit;
  logic            err_event;
  logic [31:0]     err_src;

  addr_region_decode u_decode (
    .mem_addr (mem_addr),
    .onehot   (decoded)
  );

  assign idle   = (state_reg == IDLE);
  // Reset gates the strobes so nothing leaks out while rst is held
  assign wr_acc = idle & ~rst & (|mem_wmask);
  assign rd_acc = idle & ~rst & mem_rstrb & ~(|mem_wmask);
  assign acc    = wr_acc | rd_acc;

  assign rd = rd_acc ? decoded : '0;
  assign wr = wr_acc ? decoded : '0;

`ifdef PERIPH_DEC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      addr_reg;

  assign sel_ready   = cs[CS_RAM] | (|(cs[CS_W-1:1] & io_ready));
  assign timeout_hit = (cnt_reg == CNT_LAST);
  // The access address is gone by the time a timeout fires, so it is kept from cycle T
  assign err_event   = ~idle & ~sel_ready & timeout_hit;
  assign err_src     = addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      addr_reg <= '0;
    end else begin
      cnt_reg <= idle ? '0 : cnt_reg + CNT_W'(1);
      if (acc) addr_reg <= mem_addr;
    end
  end
`else
  // Without a counter an unmapped access must not hang, so it completes at once
  assign sel_ready   = cs[CS_RAM] | (|(cs[CS_W-1:1] & io_ready)) | (cs == '0);
  assign timeout_hit = 1'b0;
  assign err_event   = acc & (decoded == '0);
  assign err_src     = mem_addr;
`endif

  assign mem_rbusy = (state_reg == WAIT_R) & ~sel_ready & ~timeout_hit;
  assign mem_wbusy = (state_reg == WAIT_W) & ~sel_ready & ~timeout_hit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (wr_acc)      state_next = WAIT_W;
        else if (rd_acc) state_next = WAIT_R;
      end
      WAIT_R, WAIT_W: begin
        if (sel_ready || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cs        <= '0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      state_reg <= state_next;
      // cs holds between accesses so the mux output stays stable for the CPU
      if (acc)
        cs <= decoded;
      else if (~idle & ~sel_ready & timeout_hit)
        cs <= '0;
      if (err_event) begin
        bus_err <= 1'b1;
        if (!bus_err) err_addr <= err_src;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_decoder.sv
// Directed self-checking bench for peripheral_decoder; covers PERIPH_DEC_TIMEOUT_EN on or off.
module tb_peripheral_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [5:0]  io_ready;
  logic [6:0]  rd, wr, cs;
  logic        mem_rbusy, mem_wbusy, bus_err;
  logic [31:0] err_addr;

  int compared   = 0;
  int mismatched = 0;

  peripheral_decoder #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_wmask (mem_wmask),
    .io_ready  (io_ready),
    .rd        (rd),
    .wr        (wr),
    .cs        (cs),
    .mem_rbusy (mem_rbusy),
    .mem_wbusy (mem_wbusy),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_addr = '0; mem_rstrb = 1'b0; mem_wmask = '0; io_ready = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cs", 32'(cs), 32'h0);
    check("rst_rd", 32'(rd), 32'h0);
    check("rst_wr", 32'(wr), 32'h0);
    check("rst_rbusy", 32'(mem_rbusy), 32'h0);
    check("rst_wbusy", 32'(mem_wbusy), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    @(negedge clk); rst = 1'b0;

    // RAM read: zero stall
    @(negedge clk); mem_addr = 32'h0000_0100; mem_rstrb = 1'b1; #1;
    check("ram_rd", 32'(rd), 32'h01);
    check("ram_wr", 32'(wr), 32'h00);
    check("ram_rbusy_T", 32'(mem_rbusy), 32'h0);
    @(negedge clk); mem_rstrb = 1'b0; #1;
    check("ram_cs", 32'(cs), 32'h01);
    check("ram_rbusy_T1", 32'(mem_rbusy), 32'h0);

    // UART write with target already ready
    @(negedge clk); mem_addr = 32'h0041_0004; mem_wmask = 4'hF; io_ready = 6'b010000; #1;
    check("uart_wr", 32'(wr), 32'h20);
    check("uart_rd", 32'(rd), 32'h00);
    check("uart_wbusy_T", 32'(mem_wbusy), 32'h0);
    @(negedge clk); mem_wmask = 4'h0; #1;
    check("uart_cs", 32'(cs), 32'h20);
    check("uart_wbusy_T1", 32'(mem_wbusy), 32'h0);
    @(negedge clk); io_ready = '0;

    // Mult read, ready arrives at T+4; a strobe during the wait is ignored
    @(negedge clk); mem_addr = 32'h0043_0000; mem_rstrb = 1'b1; #1;
    check("mult_rd", 32'(rd), 32'h08);
    @(negedge clk); mem_rstrb = 1'b0; #1;
    check("mult_cs", 32'(cs), 32'h08);
    check("mult_rbusy_T1", 32'(mem_rbusy), 32'h1);
    @(negedge clk); mem_addr = 32'h0000_0100; mem_wmask = 4'hF; #1;
    check("wait_wr_ignored", 32'(wr), 32'h00);
    check("wait_rd_ignored", 32'(rd), 32'h00);
    check("mult_rbusy_T2", 32'(mem_rbusy), 32'h1);
    @(negedge clk); mem_wmask = 4'h0; #1;
    check("mult_rbusy_T3", 32'(mem_rbusy), 32'h1);
    check("wait_cs_held", 32'(cs), 32'h08);
    @(negedge clk); io_ready = 6'b000100; #1;
    check("mult_rbusy_T4", 32'(mem_rbusy), 32'h0);
    @(negedge clk); io_ready = '0; mem_addr = 32'h0000_0100; mem_rstrb = 1'b1; #1;
    check("idle_T5_rd", 32'(rd), 32'h01);
    @(negedge clk); mem_rstrb = 1'b0; #1;
    check("idle_T5_cs", 32'(cs), 32'h01);

`ifdef PERIPH_DEC_TIMEOUT_EN
    // Unmapped read times out after 15 stalled cycles
    @(negedge clk); mem_addr = 32'h0046_0000; mem_rstrb = 1'b1; #1;
    check("unm_rd", 32'(rd), 32'h00);
    @(negedge clk); mem_rstrb = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      #1;
      check($sformatf("unm_rbusy_T%0d", k), 32'(mem_rbusy), 32'h1);
      @(negedge clk);
    end
    #1;
    check("unm_rbusy_T16", 32'(mem_rbusy), 32'h0);
    check("unm_bus_err_T16", 32'(bus_err), 32'h0);
    @(negedge clk); #1;
    check("unm_bus_err", 32'(bus_err), 32'h1);
    check("unm_err_addr", err_addr, 32'h0046_0000);
    check("unm_cs", 32'(cs), 32'h00);

    // Stuck mult read: cs cleared, first error address kept
    @(negedge clk); mem_addr = 32'h0043_0000; mem_rstrb = 1'b1; #1;
    check("stuck_rd", 32'(rd), 32'h08);
    @(negedge clk); mem_rstrb = 1'b0; #1;
    check("stuck_cs", 32'(cs), 32'h08);
    repeat (15) @(negedge clk);
    #1;
    check("stuck_rbusy_T16", 32'(mem_rbusy), 32'h0);
    @(negedge clk); #1;
    check("stuck_cs_cleared", 32'(cs), 32'h00);
    check("stuck_err_addr", err_addr, 32'h0046_0000);
    check("stuck_bus_err", 32'(bus_err), 32'h1);
`else
    // Unmapped read completes without stall and flags the error at T+1
    @(negedge clk); mem_addr = 32'h0047_0000; mem_rstrb = 1'b1; #1;
    check("unm_rd", 32'(rd), 32'h00);
    check("unm_rbusy_T", 32'(mem_rbusy), 32'h0);
    @(negedge clk); mem_rstrb = 1'b0; #1;
    check("unm_rbusy_T1", 32'(mem_rbusy), 32'h0);
    check("unm_bus_err", 32'(bus_err), 32'h1);
    check("unm_err_addr", err_addr, 32'h0047_0000);
    check("unm_cs", 32'(cs), 32'h00);
    @(negedge clk); mem_addr = 32'h0046_0000; mem_wmask = 4'hF; #1;
    check("unm2_wr", 32'(wr), 32'h00);
    check("unm2_wbusy_T", 32'(mem_wbusy), 32'h0);
    @(negedge clk); mem_wmask = 4'h0; #1;
    check("unm2_wbusy_T1", 32'(mem_wbusy), 32'h0);
    check("unm2_err_addr_kept", err_addr, 32'h0047_0000);
    check("unm2_bus_err", 32'(bus_err), 32'h1);
`endif

    // Write wins over simultaneous read; then reset during a read wait
    @(negedge clk); mem_addr = 32'h0042_0000; mem_rstrb = 1'b1; mem_wmask = 4'h3; #1;
    check("both_wr", 32'(wr), 32'h10);
    check("both_rd", 32'(rd), 32'h00);
    @(negedge clk); mem_rstrb = 1'b0; mem_wmask = 4'h0; io_ready = 6'b001000; #1;
    check("both_wbusy", 32'(mem_wbusy), 32'h0);
    check("both_rbusy", 32'(mem_rbusy), 32'h0);
    check("both_cs", 32'(cs), 32'h10);
    @(negedge clk); io_ready = '0; mem_addr = 32'h0043_0000; mem_rstrb = 1'b1; #1;
    check("pre_rst_rd", 32'(rd), 32'h08);
    @(negedge clk); mem_rstrb = 1'b0; #1;
    check("pre_rst_rbusy", 32'(mem_rbusy), 32'h1);
    @(negedge clk); mem_addr = 32'h0000_0100; mem_rstrb = 1'b1; rst = 1'b1; #1;
    check("mid_rst_rbusy", 32'(mem_rbusy), 32'h0);
    check("mid_rst_wbusy", 32'(mem_wbusy), 32'h0);
    check("mid_rst_rd", 32'(rd), 32'h00);
    check("mid_rst_wr", 32'(wr), 32'h00);
    check("mid_rst_cs", 32'(cs), 32'h00);
    check("mid_rst_bus_err", 32'(bus_err), 32'h0);
    check("mid_rst_err_addr", err_addr, 32'h0);
    @(negedge clk); rst = 1'b0; mem_rstrb = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
